// File: rtl/alu_ctrl_seq.sv
// ALU control decode and multi-cycle sequencer for the RV32 ID/EX boundary.
// Decodes {funct7,funct3} and ALUOp into a registered ALU control code, stalls the upstream
// stage while a multi-cycle op (MUL, optionally DIV) is in flight and pulses valid_o on
// completion. Optional feature macro: ALU_CTRL_DIV_EN adds a multi-cycle DIV decode (code B).
module alu_ctrl_seq #(
    parameter int unsigned CTRL_W  = 4,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DIV_LAT = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [9:0]        funct_i,
    input  logic [1:0]        ALUOp_i,
    input  logic              flush_i,
    output logic [CTRL_W-1:0] ALUCtrl_o,
    output logic              valid_o,
    output logic              stall_o,
    output logic              illegal_o,
    output logic [CNT_W-1:0]  mc_count_o
);

    localparam logic [3:0] CodeAnd  = 4'h0;
    localparam logic [3:0] CodeXor  = 4'h1;
    localparam logic [3:0] CodeSll  = 4'h2;
    localparam logic [3:0] CodeAdd  = 4'h3;
    localparam logic [3:0] CodeSub  = 4'h4;
    localparam logic [3:0] CodeMul  = 4'h5;
    localparam logic [3:0] CodeAddi = 4'h6;
    localparam logic [3:0] CodeSrai = 4'h7;
    localparam logic [3:0] CodeLw   = 4'h8;
    localparam logic [3:0] CodeSw   = 4'h9;
    localparam logic [3:0] CodeBeq  = 4'hA;
`ifdef ALU_CTRL_DIV_EN
    localparam logic [3:0] CodeDiv  = 4'hB;
    localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
`else
    localparam int unsigned MaxLat = MUL_LAT;
`endif
    // Counter holds LAT-1 down to 0.
    localparam int unsigned CntW = (MaxLat > 1) ? $clog2(MaxLat) : 1;

    // Reject parameter sets the decoder cannot honour.
    if (CTRL_W < 4 || MUL_LAT < 1 || DIV_LAT < 1 || CNT_W < 1) begin : g_param_err
        $error("alu_ctrl_seq: CTRL_W must be >= 4 and latencies/CNT_W >= 1");
    end

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              valid_q, valid_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  mc_q, mc_d;

    logic [3:0]        dec_code;
    logic              dec_ill;
    logic              dec_mul;
    logic              dec_div;
    logic              dec_multi;
    logic [CntW-1:0]   dec_lat_m1;
    logic              stall;
    logic              accept;

    // Decode {funct7,funct3} and ALUOp into a control code and an illegal flag.
    always_comb begin
        dec_code = CodeAdd;
        dec_ill  = 1'b0;
        dec_mul  = 1'b0;
        dec_div  = 1'b0;
        unique case (ALUOp_i)
            2'b10: begin
                case (funct_i)
                    10'b0000000111: dec_code = CodeAnd;
                    10'b0000000100: dec_code = CodeXor;
                    10'b0000000001: dec_code = CodeSll;
                    10'b0000000000: dec_code = CodeAdd;
                    10'b0100000000: dec_code = CodeSub;
                    10'b0000001000: begin
                        dec_code = CodeMul;
                        dec_mul  = 1'b1;
                    end
`ifdef ALU_CTRL_DIV_EN
                    10'b0000001100: begin
                        dec_code = CodeDiv;
                        dec_div  = 1'b1;
                    end
`endif
                    default: begin
                        dec_code = CodeAdd;
                        dec_ill  = 1'b1;
                    end
                endcase
            end
            2'b00: begin
                case (funct_i[2:0])
                    3'b000:  dec_code = CodeAddi;
                    3'b101:  dec_code = CodeSrai;
                    3'b010:  dec_code = CodeLw;
                    default: begin
                        dec_code = CodeAnd;
                        dec_ill  = 1'b1;
                    end
                endcase
            end
            2'b01:   dec_code = CodeSw;
            2'b11:   dec_code = CodeBeq;
            default: dec_code = CodeAdd;
        endcase
    end

    // Classify the decoded op as single- or multi-cycle and pick its countdown start.
    always_comb begin
        dec_multi  = 1'b0;
        dec_lat_m1 = '0;
        if (dec_mul && (MUL_LAT > 1)) begin
            dec_multi  = 1'b1;
            dec_lat_m1 = CntW'(MUL_LAT - 1);
        end
`ifdef ALU_CTRL_DIV_EN
        if (dec_div && (DIV_LAT > 1)) begin
            dec_multi  = 1'b1;
            dec_lat_m1 = CntW'(DIV_LAT - 1);
        end
`else
        // DIV never decodes without the feature; keep the net tied off.
        if (dec_div) begin
            dec_multi = 1'b0;
        end
`endif
    end

    // Stall while a multi-cycle op still has cycles left; the completion cycle is open.
    always_comb begin
        stall  = (state_q == StBusy) && (cnt_q != '0);
        accept = valid_i && !stall && !flush_i;
    end

    // Next-state: flush wins over everything, then countdown, then a newly accepted op.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        mc_d      = mc_q;
        if (flush_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            if (state_q == StBusy) begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                    // Completion becomes visible as cnt reaches zero.
                    if (cnt_q == CntW'(1)) begin
                        valid_d = 1'b1;
                        if (mc_q != '1) begin
                            mc_d = mc_q + CNT_W'(1);
                        end
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            if (accept) begin
                ctrl_d    = CTRL_W'(dec_code);
                illegal_d = dec_ill;
                if (dec_multi) begin
                    state_d = StBusy;
                    cnt_d   = dec_lat_m1;
                end else begin
                    valid_d = 1'b1;
                end
            end
        end
    end

    // State and registered outputs with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ctrl_q    <= CTRL_W'(CodeAdd);
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            mc_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            mc_q      <= mc_d;
        end
    end

    assign ALUCtrl_o  = ctrl_q;
    assign valid_o    = valid_q;
    assign stall_o    = stall;
    assign illegal_o  = illegal_q;
    assign mc_count_o = mc_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: stimulus pushes expected {code, illegal} into a queue and a
// negedge monitor pops on every valid_o. Timing checks (stall, latency, counters) are made
// directly one time unit after the active edge. Honours ALU_CTRL_DIV_EN for the DIV case.
module tb_alu_ctrl_seq;

    typedef struct packed {
        logic [3:0] code;
        logic       ill;
    } exp_t;

    logic        clk;
    logic        rst;

    // Main DUT: default parameters
    logic        a_valid_i;
    logic [9:0]  a_funct;
    logic [1:0]  a_op;
    logic        a_flush;
    logic [3:0]  a_ctrl;
    logic        a_valid_o;
    logic        a_stall;
    logic        a_ill;
    logic [15:0] a_mc;

    // Shared stimulus for the saturation (b) and unit-latency (c) instances
    logic        s_valid;
    logic [9:0]  s_funct;
    logic [1:0]  s_op;
    logic        s_flush;
    logic [3:0]  b_ctrl;
    logic        b_valid_o;
    logic        b_stall;
    logic        b_ill;
    logic [1:0]  b_mc;
    logic [3:0]  c_ctrl;
    logic        c_valid_o;
    logic        c_stall;
    logic        c_ill;
    logic [15:0] c_mc;

    int          n_cmp;
    int          n_err;
    exp_t        q[$];
    exp_t        mon_e;
    int          lat;

    alu_ctrl_seq u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .valid_i    (a_valid_i),
        .funct_i    (a_funct),
        .ALUOp_i    (a_op),
        .flush_i    (a_flush),
        .ALUCtrl_o  (a_ctrl),
        .valid_o    (a_valid_o),
        .stall_o    (a_stall),
        .illegal_o  (a_ill),
        .mc_count_o (a_mc)
    );

    alu_ctrl_seq #(
        .CNT_W   (2),
        .MUL_LAT (3)
    ) u_dut_sat (
        .clk_i      (clk),
        .rst_i      (rst),
        .valid_i    (s_valid),
        .funct_i    (s_funct),
        .ALUOp_i    (s_op),
        .flush_i    (s_flush),
        .ALUCtrl_o  (b_ctrl),
        .valid_o    (b_valid_o),
        .stall_o    (b_stall),
        .illegal_o  (b_ill),
        .mc_count_o (b_mc)
    );

    alu_ctrl_seq #(
        .MUL_LAT (1)
    ) u_dut_lat1 (
        .clk_i      (clk),
        .rst_i      (rst),
        .valid_i    (s_valid),
        .funct_i    (s_funct),
        .ALUOp_i    (s_op),
        .flush_i    (s_flush),
        .ALUCtrl_o  (c_ctrl),
        .valid_o    (c_valid_o),
        .stall_o    (c_stall),
        .illegal_o  (c_ill),
        .mc_count_o (c_mc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Single-cycle decode: expected result queued, valid_o checked at T+1.
    task automatic sweep_one(input logic [9:0] f, input logic [1:0] op, input logic [3:0] code,
                             input logic ill);
        q.push_back({code, ill});
        a_valid_i = 1'b1;
        a_funct   = f;
        a_op      = op;
        tick();
        a_valid_i = 1'b0;
        chk("sweep_valid", 32'(a_valid_o), 32'd1);
    endtask

    // Scoreboard monitor: every valid_o pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && a_valid_o) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected_valid: got ctrl %0h ill %0b, expected no output",
                         a_ctrl, a_ill);
            end else begin
                mon_e = q.pop_front();
                chk("sb_ctrl", 32'(a_ctrl), 32'(mon_e.code));
                chk("sb_illegal", 32'(a_ill), 32'(mon_e.ill));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b0;
        a_valid_i = 1'b0;
        a_funct   = '0;
        a_op      = 2'b00;
        a_flush   = 1'b0;
        s_valid   = 1'b0;
        s_funct   = '0;
        s_op      = 2'b00;
        s_flush   = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_ctrl", 32'(a_ctrl), 32'h3);
        chk("rst_valid", 32'(a_valid_o), 32'd0);
        chk("rst_stall", 32'(a_stall), 32'd0);
        chk("rst_mc", 32'(a_mc), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Decode sweep, back-to-back single-cycle ops
        sweep_one(10'b0100000000, 2'b10, 4'h4, 1'b0);
        sweep_one(10'b0000000111, 2'b10, 4'h0, 1'b0);
        sweep_one(10'b0000000100, 2'b10, 4'h1, 1'b0);
        sweep_one(10'b0000000001, 2'b10, 4'h2, 1'b0);
        sweep_one(10'b0000000000, 2'b10, 4'h3, 1'b0);
        sweep_one(10'b0100000101, 2'b00, 4'h7, 1'b0);
        sweep_one(10'b1111111000, 2'b00, 4'h6, 1'b0);
        sweep_one(10'b0000000010, 2'b00, 4'h8, 1'b0);
        sweep_one(10'b1111111111, 2'b01, 4'h9, 1'b0);
        sweep_one(10'b0000000111, 2'b11, 4'hA, 1'b0);
        sweep_one(10'b0000000010, 2'b10, 4'h3, 1'b1);
        sweep_one(10'b0000000011, 2'b00, 4'h0, 1'b1);

        // Idle cycle: no pulse, code held
        tick();
        chk("noop_valid", 32'(a_valid_o), 32'd0);
        chk("noop_illegal", 32'(a_ill), 32'd0);
        chk("noop_hold", 32'(a_ctrl), 32'h0);

        // MUL, then ADD presented while stalled and accepted in the completion cycle
        q.push_back({4'h5, 1'b0});
        a_valid_i = 1'b1;
        a_funct   = 10'b0000001000;
        a_op      = 2'b10;
        tick();
        a_valid_i = 1'b0;
        chk("mul_ctrl_t1", 32'(a_ctrl), 32'h5);
        chk("mul_stall_t1", 32'(a_stall), 32'd1);
        chk("mul_novalid_t1", 32'(a_valid_o), 32'd0);
        tick();
        chk("mul_stall_t2", 32'(a_stall), 32'd1);
        q.push_back({4'h3, 1'b0});
        a_valid_i = 1'b1;
        a_funct   = 10'b0000000000;
        a_op      = 2'b10;
        tick();
        chk("mul_valid_t3", 32'(a_valid_o), 32'd1);
        chk("mul_stall_t3", 32'(a_stall), 32'd0);
        chk("mul_mc_t3", 32'(a_mc), 32'd1);
        tick();
        a_valid_i = 1'b0;
        chk("b2b_valid_t4", 32'(a_valid_o), 32'd1);
        chk("b2b_ctrl_t4", 32'(a_ctrl), 32'h3);
        chk("b2b_mc_t4", 32'(a_mc), 32'd1);

        // MUL aborted by flush at T+2
        a_valid_i = 1'b1;
        a_funct   = 10'b0000001000;
        a_op      = 2'b10;
        tick();
        a_valid_i = 1'b0;
        tick();
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        chk("flush_stall", 32'(a_stall), 32'd0);
        chk("flush_valid", 32'(a_valid_o), 32'd0);
        chk("flush_mc", 32'(a_mc), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_no_pulse", 32'(a_valid_o), 32'd0);
        end

        // Flush beats a concurrent request
        a_flush   = 1'b1;
        a_valid_i = 1'b1;
        a_funct   = 10'b0000000000;
        a_op      = 2'b10;
        tick();
        a_flush   = 1'b0;
        a_valid_i = 1'b0;
        chk("flush_vs_valid", 32'(a_valid_o), 32'd0);
        chk("flush_vs_ctrl", 32'(a_ctrl), 32'h5);

        // DIV encoding
`ifdef ALU_CTRL_DIV_EN
        q.push_back({4'hB, 1'b0});
        a_valid_i = 1'b1;
        a_funct   = 10'b0000001100;
        a_op      = 2'b10;
        tick();
        a_valid_i = 1'b0;
        chk("div_stall_t1", 32'(a_stall), 32'd1);
        lat = 1;
        while (!a_valid_o && lat < 20) begin
            tick();
            lat++;
        end
        chk("div_latency", 32'(lat), 32'd8);
        chk("div_mc", 32'(a_mc), 32'd2);
`else
        q.push_back({4'h3, 1'b1});
        a_valid_i = 1'b1;
        a_funct   = 10'b0000001100;
        a_op      = 2'b10;
        tick();
        a_valid_i = 1'b0;
        chk("nodiv_valid", 32'(a_valid_o), 32'd1);
        chk("nodiv_stall", 32'(a_stall), 32'd0);
        chk("nodiv_mc", 32'(a_mc), 32'd1);
`endif
        tick();

        // Asynchronous reset while BUSY
        a_valid_i = 1'b1;
        a_funct   = 10'b0000001000;
        a_op      = 2'b10;
        tick();
        a_valid_i = 1'b0;
        chk("rstbusy_stall_pre", 32'(a_stall), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstbusy_ctrl", 32'(a_ctrl), 32'h3);
        chk("rstbusy_valid", 32'(a_valid_o), 32'd0);
        chk("rstbusy_stall", 32'(a_stall), 32'd0);
        chk("rstbusy_mc", 32'(a_mc), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rstbusy_lost", 32'(a_valid_o), 32'd0);
        end

        // Saturating counter (CNT_W=2) and MUL_LAT=1 behaviour
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_funct = 10'b0000001000;
            s_op    = 2'b10;
            tick();
            s_valid = 1'b0;
            chk("lat1_valid", 32'(c_valid_o), 32'd1);
            chk("lat1_ctrl", 32'(c_ctrl), 32'h5);
            chk("lat1_stall", 32'(c_stall), 32'd0);
            chk("sat_stall", 32'(b_stall), 32'd1);
            tick();
            chk("lat1_pulse", 32'(c_valid_o), 32'd0);
            tick();
            chk("sat_valid", 32'(b_valid_o), 32'd1);
            chk("sat_mc", 32'(b_mc), (i < 3) ? 32'(i + 1) : 32'd3);
        end

        tick();
        tick();
        chk("sb_drain", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
